// File: rtl/pc_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_if
// Bundles the control inputs and status outputs of the PC fetch stage.
//   Control (master -> slave): stall, halt_req, branch_taken, branch_imm,
//                              jump, jump_addr
//   Status  (slave -> master): pcread, pc_plus4, fetch_valid, halted,
//                              misalign, instr_count
// The fetch unit connects through the slave modport. The controlling
// datapath or bench connects through the master modport.
// ---------------------------------------------------------------------------
interface pc_fetch_unit_if;
    logic        stall;
    logic        halt_req;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_addr;
    logic [31:0] pcread;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic        misalign;
    logic [31:0] instr_count;

    modport master (
        output stall, halt_req, branch_taken, branch_imm, jump, jump_addr,
        input  pcread, pc_plus4, fetch_valid, halted, misalign, instr_count
    );

    modport slave (
        input  stall, halt_req, branch_taken, branch_imm, jump, jump_addr,
        output pcread, pc_plus4, fetch_valid, halted, misalign, instr_count
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Program-counter stage in front of the instruction memory. It holds the PC
// and selects the next PC from four sources: hold, sequential, branch or
// jump. It also runs a BOOT -> RUN -> HALT sequence, so fetching stops once
// the PC leaves the loaded program.
//
// Ports:
//   clk    - system clock. All state changes on its rising edge.
//   reset  - asynchronous, active-high reset.
//   bus    - pc_fetch_unit_if.slave:
//              stall, halt_req, branch_taken, branch_imm[15:0],
//              jump, jump_addr[25:0]                        (inputs)
//              pcread[31:0], pc_plus4[31:0], fetch_valid,
//              halted, misalign, instr_count[31:0]          (outputs)
//
// Build option:
//   PC_FETCH_PERF_EN - when defined, instr_count counts the RUN edges that
//                      advance the PC. When undefined, instr_count is
//                      tied to zero.
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT = 32'd64
) (
    input  logic            clk,
    input  logic            reset,
    pc_fetch_unit_if.slave  bus
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]  state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        misalign_reg, misalign_next;

    logic [31:0] pc_plus4_w;
    logic [31:0] branch_off;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        redirect;
    logic        target_misaligned;

    assign pc_plus4_w = pc_reg + 32'd4;
    // The offset is counted in words: sign-extend it, then shift it into bytes.
    assign branch_off = {{14{bus.branch_imm[15]}}, bus.branch_imm, 2'b00};

    // Select the candidate next PC. Jump has priority over branch.
    always_comb begin
        redirect   = 1'b0;
        target_raw = pc_plus4_w;
        if (bus.jump) begin
            redirect   = 1'b1;
            target_raw = {pc_plus4_w[31:28], bus.jump_addr, 2'b00};
        end else if (bus.branch_taken) begin
            redirect   = 1'b1;
            target_raw = pc_plus4_w + branch_off;
        end
    end

    // Only redirect targets are forced to word alignment.
    // The sequential path keeps the alignment of RESET_PC.
    assign target_misaligned = redirect && (target_raw[1:0] != 2'b00);
    assign target = target_misaligned ? {target_raw[31:2], 2'b00} : target_raw;

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        misalign_next = misalign_reg;
        case (state_reg)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN: begin
                if (bus.halt_req) begin
                    state_next = ST_HALT;
                end else if (!bus.stall) begin
                    pc_next = target;
                    if (target_misaligned) begin
                        misalign_next = 1'b1;
                    end
                    // The PC still takes the out-of-range value, so it shows
                    // where the fetch went before the unit stopped.
                    if (target >= PC_LIMIT) begin
                        state_next = ST_HALT;
                    end
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_BOOT;
            pc_reg       <= RESET_PC;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            misalign_reg <= misalign_next;
        end
    end

`ifdef PC_FETCH_PERF_EN
    logic [31:0] count_reg;
    logic        count_en;

    assign count_en = (state_reg == ST_RUN) && !bus.halt_req && !bus.stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= 32'h0;
        end else if (count_en) begin
            count_reg <= count_reg + 32'd1;
        end
    end

    assign bus.instr_count = count_reg;
`else
    assign bus.instr_count = 32'h0;
`endif

    assign bus.pcread      = pc_reg;
    assign bus.pc_plus4    = pc_plus4_w;
    assign bus.fetch_valid = (state_reg == ST_RUN);
    assign bus.halted      = (state_reg == ST_HALT);
    assign bus.misalign    = misalign_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
// Drives random and directed fetch-control patterns into pc_fetch_unit.
// For each cycle, a reference model of the PC rules pushes the expected
// post-edge outputs into a queue. A monitor pops one entry after every
// rising edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

    localparam logic [31:0] LIMIT = 32'd64;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk;
    logic reset;

    pc_fetch_unit_if bus();

    pc_fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic        hl;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_state;
    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] exp_count(input logic [31:0] c);
`ifdef PC_FETCH_PERF_EN
        return c;
`else
        return 32'h0 & c;
`endif
    endfunction

    task automatic model_reset();
        m_state = M_BOOT;
        m_pc    = 32'h0;
        m_mis   = 1'b0;
        m_cnt   = 32'h0;
    endtask

    // Drive one cycle of inputs on the falling edge. Advance the model by
    // the edge that follows, and queue the outputs expected after it.
    task automatic step(input logic s, input logic h, input logic b,
                        input logic [15:0] imm, input logic j, input logic [25:0] ja);
        logic [31:0] p4;
        logic [31:0] tgt;
        logic        redir;
        exp_t        e;
        @(negedge clk);
        bus.stall        = s;
        bus.halt_req     = h;
        bus.branch_taken = b;
        bus.branch_imm   = imm;
        bus.jump         = j;
        bus.jump_addr    = ja;
        p4 = m_pc + 32'd4;
        if (m_state == M_BOOT) begin
            m_state = M_RUN;
        end else if (m_state == M_RUN) begin
            if (h) begin
                m_state = M_HALT;
            end else if (!s) begin
                redir = j | b;
                if (j)      tgt = {p4[31:28], ja, 2'b00};
                else if (b) tgt = p4 + 32'($signed(imm)) * 32'd4;
                else        tgt = p4;
                if (redir && (tgt % 4 != 0)) begin
                    tgt   = tgt - (tgt % 4);
                    m_mis = 1'b1;
                end
                m_pc  = tgt;
                m_cnt = m_cnt + 1;
                if (tgt >= LIMIT) m_state = M_HALT;
            end
        end
        e.pc  = m_pc;
        e.fv  = (m_state == M_RUN);
        e.hl  = (m_state == M_HALT);
        e.mis = m_mis;
        e.cnt = exp_count(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 16'h0, 0, 26'h0);
    endtask

    // Pulse reset between edges, after the monitor has taken its sample
    // for this cycle, and check the reset values immediately.
    task automatic pulse_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_pcread", bus.pcread, 32'h0);
        chk("rst_halted", {31'h0, bus.halted}, 32'h0);
        chk("rst_fetch_valid", {31'h0, bus.fetch_valid}, 32'h0);
        chk("rst_misalign", {31'h0, bus.misalign}, 32'h0);
        chk("rst_instr_count", bus.instr_count, 32'h0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expected entry per rising edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pcread", bus.pcread, e.pc);
            chk("pc_plus4", bus.pc_plus4, e.pc + 32'd4);
            chk("fetch_valid", {31'h0, bus.fetch_valid}, {31'h0, e.fv});
            chk("halted", {31'h0, bus.halted}, {31'h0, e.hl});
            chk("misalign", {31'h0, bus.misalign}, {31'h0, e.mis});
            chk("instr_count", bus.instr_count, e.cnt);
        end
    end

    initial begin
        logic [15:0] r_imm;
        logic [25:0] r_ja;
        int          halt_cycles;
        reset            = 1'b1;
        bus.stall        = 1'b0;
        bus.halt_req     = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_imm   = 16'h0;
        bus.jump         = 1'b0;
        bus.jump_addr    = 26'h0;
        model_reset();
        #12;
        chk("init_pcread", bus.pcread, 32'h0);
        chk("init_fetch_valid", {31'h0, bus.fetch_valid}, 32'h0);
        pulse_reset();

        // Test 1: BOOT, then sequential fetches
        idle(4);

        // Test 2: branch from 60 with offset -8 words
        step(0, 0, 0, 16'h0, 1, 26'd15);
        step(0, 0, 1, 16'hFFF8, 0, 26'h0);
        after_edge();
        chk("t2_branch_pc", bus.pcread, 32'd32);
        chk("t2_running", {31'h0, bus.fetch_valid}, 32'd1);

        // Test 3: jump and branch together at PC 8
        step(0, 0, 0, 16'h0, 1, 26'd2);
        step(0, 0, 1, 16'h0010, 1, 26'h5);
        after_edge();
        chk("t3_jump_wins", bus.pcread, 32'd20);

        // Test 4: stall for three cycles at PC 16
        step(0, 0, 0, 16'h0, 1, 26'd4);
        for (int k = 0; k < 3; k++) step(1, 0, 1, 16'h0003, 1, 26'h7);
        after_edge();
        chk("t4_stall_hold", bus.pcread, 32'd16);
        step(0, 0, 0, 16'h0, 0, 26'h0);
        after_edge();
        chk("t4_resume", bus.pcread, 32'd20);

        // Test 5: run past the limit, then stay frozen
        idle(11);
        after_edge();
        chk("t5_limit_pc", bus.pcread, 32'd64);
        chk("t5_halted", {31'h0, bus.halted}, 32'd1);
        for (int k = 0; k < 10; k++) step(k[0], k[1], 1, 16'h0002, k[2], 26'h3);
        after_edge();
        chk("t5_frozen", bus.pcread, 32'd64);

        // Test 6: asynchronous reset at PC 28
        pulse_reset();
        step(0, 0, 0, 16'h0, 0, 26'h0);
        step(0, 0, 0, 16'h0, 1, 26'd7);
        bus.stall = 1'b0;
        bus.jump  = 1'b1;
        pulse_reset();

        // Backward branch from PC 0 wraps around and halts
        step(0, 0, 0, 16'h0, 0, 26'h0);
        step(0, 0, 1, 16'hFFF0, 0, 26'h0);
        after_edge();
        chk("wrap_pc", bus.pcread, 32'hFFFF_FFC4);
        chk("wrap_halted", {31'h0, bus.halted}, 32'd1);
        pulse_reset();

        // Random phase
        halt_cycles = 0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 9) == 0) r_imm = 16'($urandom);
            else r_imm = 16'(int'($urandom_range(0, 15)) - 8);
            if ($urandom_range(0, 19) == 0) r_ja = 26'($urandom);
            else r_ja = 26'($urandom_range(0, 20));
            step($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) == 0, r_imm, $urandom_range(0, 7) == 0, r_ja);
            if (m_state == M_HALT) halt_cycles++;
            if (halt_cycles > 3 || $urandom_range(0, 199) == 0) begin
                halt_cycles = 0;
                pulse_reset();
            end
        end

        after_edge();
        after_edge();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
